// File: rtl/pe_pkg.sv
// pe_pkg: shared widths and the index-width helper for the PE memory arbiter
package pe_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 32;
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin pick of the first req at or after ptr, as one-hot gnt plus index
//   req/ptr in; gnt (one-hot), idx (granted requester), any (some req high) out
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [N-1:0]  rot;
  logic [IW-1:0] off;
  logic [IW:0]   sum;
  always_comb begin
    rot = N'({req, req} >> ptr);
    off = '0;
    for (int i = N - 1; i >= 0; i--) off = rot[i] ? IW'(i) : off;
    sum = {1'b0, off} + {1'b0, ptr};
    idx = (sum >= (IW + 1)'(N)) ? IW'(sum - (IW + 1)'(N)) : sum[IW-1:0];
    any = |req;
    gnt = any ? (N'(1) << idx) : '0;
  end
endmodule

// File: rtl/pe_mem_arbiter.sv
// pe_mem_arbiter: round-robin share of one sync-read memory port among NUM_REQ PEs
//   req/addr/hold in -> gnt, mem_en, mem_addr (combinational)
//   mem_rdata in -> rvalid, rid, rdata (RD_LATENCY after grant); idle, grant_count out
module pe_mem_arbiter
  import pe_pkg::*;
#(
  parameter int NUM_REQ    = 64,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int RD_LATENCY = 1,
  localparam int IDX_W     = clog2_min1(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic                      hold,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      mem_en,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [IDX_W-1:0]          rid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      idle,
  output logic [31:0]               grant_count
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_REQ - 1);
  logic [IDX_W-1:0]   ptr_q, ptr_d, pick_idx;
  logic [NUM_REQ-1:0] req_eff;
  logic [31:0]        grant_count_q, grant_count_d;
  logic [RD_LATENCY-1:0] v_q;
  logic [IDX_W-1:0]   id_q [RD_LATENCY];
  assign req_eff = hold ? '0 : req;
  rr_pick #(.N(NUM_REQ), .IW(IDX_W)) u_pick (
    .req(req_eff),
    .ptr(ptr_q),
    .gnt(gnt),
    .idx(pick_idx),
    .any(mem_en)
  );
  always_comb begin
    mem_addr      = mem_en ? addr[pick_idx*ADDR_W +: ADDR_W] : '0;
    ptr_d         = mem_en ? ((pick_idx == LAST) ? '0 : pick_idx + 1'b1) : ptr_q;
    grant_count_d = (mem_en && grant_count_q != '1) ? grant_count_q + 32'd1 : grant_count_q;
  end
  // Return pipeline: stage 0 captures the grant, the last stage aligns with mem_rdata.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q         <= '0;
      grant_count_q <= '0;
      v_q           <= '0;
      for (int i = 0; i < RD_LATENCY; i++) id_q[i] <= '0;
    end else begin
      ptr_q         <= ptr_d;
      grant_count_q <= grant_count_d;
      v_q[0]        <= mem_en;
      id_q[0]       <= mem_en ? pick_idx : '0;
      for (int i = 1; i < RD_LATENCY; i++) begin
        v_q[i]  <= v_q[i-1];
        id_q[i] <= id_q[i-1];
      end
    end
  end
  assign rvalid      = v_q[RD_LATENCY-1] ? (NUM_REQ'(1) << id_q[RD_LATENCY-1]) : '0;
  assign rid         = id_q[RD_LATENCY-1];
  assign rdata       = mem_rdata;
  assign idle        = ~|req & ~|v_q;
  assign grant_count = grant_count_q;
endmodule

// File: doc/pe_mem_arbiter.md
Name: pe_mem_arbiter

Overview:
- Round-robin arbiter that shares one synchronous-read memory port (a left-, right- or result-operand BRAM) among the PE_Controller instances of the PE array.
- Each PE requests with an address and holds it until granted. The arbiter issues at most one memory access per cycle and returns read data to the owning PE a fixed RD_LATENCY cycles later.
- Sits between the PE array's *_mem_index outputs and the BRAM port. Provides an idle flag so the top-level sequencer can detect drain.

Parameters:
- NUM_REQ, 64, number of requesting PEs (matches PE_COUNT); legal range 1 and up.
- ADDR_W, 32, address width.
- DATA_W, 32, memory data width.
- RD_LATENCY, 1, cycles from mem_en sample edge to mem_rdata valid; legal range 1..4.
- IDX_W, max(1,$clog2(NUM_REQ)), requester index width (derived, not overridden).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  per-PE request; held high with stable addr until gnt
- addr  in  NUM_REQ*ADDR_W  flat per-PE address, PE i at bits [i*ADDR_W +: ADDR_W]
- hold  in  1  when high, no grant is issued this cycle
- gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as acceptance
- mem_en  out  1  memory read enable, combinational (=|gnt)
- mem_addr  out  ADDR_W  address of granted PE, combinational; 0 when mem_en=0
- mem_rdata  in  DATA_W  memory read data
- rvalid  out  NUM_REQ  one-hot read-return strobe, registered
- rid  out  IDX_W  index of PE receiving data this cycle
- rdata  out  DATA_W  mem_rdata passthrough, qualified by rvalid
- idle  out  1  no req asserted and no read in flight
- grant_count  out  32  total grants since reset, saturates at 0xFFFF_FFFF

Behaviour:
Reset values:
- Round-robin pointer = 0 (PE 0 highest priority).
- Return pipeline flushed, so rvalid = 0 and rid = 0.
- grant_count = 0.
- idle = 1 when req = 0.
- gnt, mem_en and mem_addr follow req combinationally, subject to the reset-state pointer.

Arbitration (combinational, each cycle):
- If hold = 1 or req = 0: gnt = 0, mem_en = 0.
- Otherwise, grant the first asserted req scanning ptr, ptr+1, ..., wrapping mod NUM_REQ.
- Exactly one gnt bit is high when any req is high and hold = 0.

Pointer update:
- On a grant to PE k, ptr <= (k+1) mod NUM_REQ at the next edge.
- Unchanged when no grant.
- A continuously requesting PE is therefore served at most once per NUM_REQ grants while others are waiting.

Requester rule:
- req and addr must be stable until the cycle gnt is seen; req may be dropped or re-armed with a new address the next cycle.
- A PE that keeps req high is eligible again immediately, still subject to the pointer.

Return pipeline:
- Shift register of {valid, idx}, depth RD_LATENCY.
- Stage 0 is loaded with {mem_en, granted idx} at each edge.
- The final stage drives rvalid (one-hot decode of idx when valid) and rid.
- rvalid for a grant at cycle t is high in cycle t+RD_LATENCY, aligned with mem_rdata.
- Back-to-back grants produce back-to-back returns in grant order. There is no back-pressure on returns.

idle:
- Combinational: (req == 0) and no valid bit in any pipeline stage.

grant_count:
- Increments on every cycle with mem_en = 1; holds at max.

Boundary conditions:
- NUM_REQ = 1: ptr is fixed at 0; PE 0 is granted whenever req & ~hold.
- hold asserted while reads are in flight: returns still complete; only new grants stop.
- rst asserted mid-operation: in-flight reads are discarded and their rvalid is never asserted; ptr and count clear immediately.
- Pointer wrap: a grant to PE NUM_REQ-1 sets ptr to 0.

Decomposition:
- Shared package pe_pkg: DATA_W/ADDR_W defaults, and function clog2_min1 for IDX_W.
- One sub-module, rr_pick: combinational rotate, priority-encode, unrotate, returning a one-hot vector and index from (req, ptr).
- The return pipeline and counters stay in pe_mem_arbiter.

Test Plan:
All scenarios use NUM_REQ=4 and RD_LATENCY=2.
1. Reset, then req=4'b0001, addr0=0x10, with mem_rdata model = addr+0x100 two cycles later -> gnt=0001 and mem_addr=0x10 in cycle 0; rvalid=0001, rid=0, rdata=0x110 in cycle 2; grant_count=1; idle=1 from cycle 3.
2. All four req held high for 8 cycles -> grant order 0,1,2,3,0,1,2,3; rvalid follows the same order two cycles later; grant_count=8.
3. req=1010, with PE 1 dropping req after its grant -> grants 1,3,3,...; after PE 1 re-requests while ptr=0, grant goes to 1 next.
4. All req high, hold=1 for cycles 2-4 -> no gnt and mem_en=0 in cycles 2-4; the return from the cycle-1 grant still appears in cycle 3; the grant in cycle 5 goes to the PE after the last granted one.
5. rst pulsed in the cycle after two grants -> rvalid stays 0 for both; ptr=0 (PE 0 wins next when all request); grant_count=0.
6. grant_count preloaded via force to 0xFFFF_FFFE, then 3 grants -> reads 0xFFFF_FFFF and holds there.
